// File: rtl/u_rec_os16_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver: state encodings,
// line levels and frame defaults.
package u_rec_os16_pkg;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  localparam int WORD_LEN_DEF = 8;
  localparam int OS_RATE_DEF  = 16;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_BREAK = 3'd4
  } rec_state_e;

  // The receiver shifts into the MSB, so a short word ends up left-aligned.
  function automatic logic [7:0] right_justify(input logic [7:0] sr, input int unsigned wl);
    return sr >> (8 - wl);
  endfunction

endpackage

// File: rtl/u_rec_os16_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module u_sync2
  import u_rec_os16_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= HI;
      sync_q <= HI;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/u_rec_os16.sv
// 8N1 UART receiver: start-edge detect, mid-cell sampling at OS_RATE x
// oversampling, ready/ack delivery with framing and overrun reporting.
module u_rec_os16
  import u_rec_os16_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int OS_RATE  = OS_RATE_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_recH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  input  logic       rec_ackH,
  output logic       frame_errH,
  output logic       overrunH,
  output logic       rec_busyH
);

  localparam int            CW       = $clog2(OS_RATE);
  localparam logic [CW-1:0] HALF_M1  = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OS_RATE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(WORD_LEN - 1);

  logic line_s;

  rec_state_e    state_q, state_d;
  logic [CW-1:0] cell_cnt_q, cell_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;

  logic busy;
  logic data_smp;
  logic deliver;
  logic stop_bad;

  u_sync2 u_sync2_i (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (uart_recH),
    .q_o   (line_s)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= R_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (line_s == LO) state_d = R_START;
      R_START: if (cell_cnt_q == HALF_M1) state_d = (line_s == LO) ? R_DATA : R_IDLE;
      R_DATA:  if (cell_cnt_q == FULL_M1 && bit_cnt_q == LAST_BIT) state_d = R_STOP;
      R_STOP:  if (cell_cnt_q == FULL_M1) state_d = (line_s == HI) ? R_IDLE : R_BREAK;
      R_BREAK: if (line_s == HI) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  // Output decode: sampling strobes derived from the current state
  always_comb begin
    busy     = (state_q != R_IDLE);
    data_smp = (state_q == R_DATA) && (cell_cnt_q == FULL_M1);
    deliver  = (state_q == R_STOP) && (cell_cnt_q == FULL_M1) && (line_s == HI);
    stop_bad = (state_q == R_STOP) && (cell_cnt_q == FULL_M1) && (line_s == LO);
  end

  // Datapath next-state; in R_DATA the cell counter wraps between bits.
  always_comb begin
    cell_cnt_d = cell_cnt_q + CW'(1);
    if (state_d != state_q || state_q == R_IDLE) cell_cnt_d = '0;

    bit_cnt_d = bit_cnt_q;
    if (state_q != R_DATA) bit_cnt_d = '0;
    else if (data_smp)     bit_cnt_d = bit_cnt_q + 4'd1;

    shift_d = shift_q;
    if (data_smp) shift_d = {line_s, shift_q[7:1]};

    data_d    = data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (rec_ackH && ready_q) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // A delivery overrides a same-cycle ack; only an unacked byte is lost.
    if (deliver) begin
      data_d  = right_justify(shift_q, WORD_LEN);
      ready_d = 1'b1;
      if (ready_q && !rec_ackH) overrun_d = 1'b1;
    end

    ferr_d = stop_bad;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cell_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      cell_cnt_q <= cell_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rec_dataH  = data_q;
  assign rec_readyH = ready_q;
  assign overrunH   = overrun_q;
  assign frame_errH = ferr_q;
  assign rec_busyH  = busy;

endmodule

// File: tb/tb_u_rec_os16.sv
// Directed bench for u_rec_os16: inputs driven and outputs sampled on the
// falling edge; frames are generated at 16 cycles per bit cell.
module tb_u_rec_os16;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       uart_recH;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       rec_ackH;
  logic       frame_errH;
  logic       overrunH;
  logic       rec_busyH;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int rise_cyc = -1;
  int ferr_cnt = 0;
  int e_tmp;
  int e_glitch;
  logic ready_prev = 1'b0;

  u_rec_os16 dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_recH  (uart_recH),
    .rec_dataH  (rec_dataH),
    .rec_readyH (rec_readyH),
    .rec_ackH   (rec_ackH),
    .frame_errH (frame_errH),
    .overrunH   (overrunH),
    .rec_busyH  (rec_busyH)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Records the posedge index at which rec_readyH rose and counts error pulses.
  always @(negedge sys_clk) begin
    if (rec_readyH === 1'b1 && ready_prev !== 1'b1) rise_cyc = cyc;
    ready_prev = rec_readyH;
    if (frame_errH === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one 8N1 frame; e returns the posedge where the first sync flop sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e);
    @(negedge sys_clk);
    uart_recH = 1'b0;
    e = cyc + 1;
    repeat (15) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      uart_recH = b[i];
      repeat (15) @(negedge sys_clk);
    end
    @(negedge sys_clk);
    uart_recH = stop_bit;
    repeat (15) @(negedge sys_clk);
  endtask

  task automatic ack_pulse();
    @(negedge sys_clk);
    rec_ackH = 1'b1;
    @(negedge sys_clk);
    rec_ackH = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst   = 1'b1;
    uart_recH = 1'b1;
    rec_ackH  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_data",  rec_dataH,  8'h00);
    check("rst_ready", rec_readyH, 1'b0);
    check("rst_busy",  rec_busyH,  1'b0);
    check("rst_ovr",   overrunH,   1'b0);
    sys_rst = 1'b0;

    // Long idle
    repeat (1000) @(negedge sys_clk);
    check("idle_busy",  rec_busyH,  1'b0);
    check("idle_ready", rec_readyH, 1'b0);
    check("idle_ferr",  ferr_cnt,   0);
    check("idle_ovr",   overrunH,   1'b0);

    // 0xA5 with exact ready timing
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, e_tmp);
    check("a5_rise",  rise_cyc,   e_tmp + 154);
    check("a5_data",  rec_dataH,  8'hA5);
    check("a5_ready", rec_readyH, 1'b1);
    ack_pulse();
    check("a5_ack",   rec_readyH, 1'b0);

    // 6-cycle glitch: busy until the mid-start sample at E+10
    repeat (4) @(negedge sys_clk);
    uart_recH = 1'b0;
    e_glitch  = cyc + 1;
    repeat (6) @(negedge sys_clk);
    uart_recH = 1'b1;
    while (cyc < e_glitch + 9) @(negedge sys_clk);
    check("gl_busy_pre",  rec_busyH, 1'b1);
    @(negedge sys_clk);
    check("gl_busy_post", rec_busyH, 1'b0);
    repeat (20) @(negedge sys_clk);
    check("gl_ready", rec_readyH, 1'b0);
    check("gl_ferr",  ferr_cnt,   0);

    // Framing error then break, then a clean 0x81
    send_frame(8'h3C, 1'b0, e_tmp);
    repeat (40) @(negedge sys_clk);
    check("fe_pulse", ferr_cnt,   1);
    check("fe_ready", rec_readyH, 1'b0);
    check("fe_break", rec_busyH,  1'b1);
    uart_recH = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("fe_idle",  rec_busyH,  1'b0);
    send_frame(8'h81, 1'b1, e_tmp);
    check("x81_data",  rec_dataH,  8'h81);
    check("x81_ready", rec_readyH, 1'b1);
    check("x81_ferr",  ferr_cnt,   1);
    ack_pulse();

    // Back-to-back without ack
    send_frame(8'h11, 1'b1, e_tmp);
    check("ov_first",  overrunH,  1'b0);
    check("ov_d11",    rec_dataH, 8'h11);
    send_frame(8'h22, 1'b1, e_tmp);
    check("ov_set",    overrunH,   1'b1);
    check("ov_d22",    rec_dataH,  8'h22);
    check("ov_ready",  rec_readyH, 1'b1);
    ack_pulse();
    check("ov_clr",    overrunH,   1'b0);
    check("ov_rdy0",   rec_readyH, 1'b0);

    // Reset during bit 4 of 0xF0 (bits 4..7 and stop are high, so no restart)
    fork
      send_frame(8'hF0, 1'b1, e_tmp);
      begin
        repeat (84) @(negedge sys_clk);
        check("mr_busy_pre", rec_busyH, 1'b1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mr_data", rec_dataH,  8'h00);
        check("mr_busy", rec_busyH,  1'b0);
        check("mr_rdy",  rec_readyH, 1'b0);
      end
    join
    repeat (20) @(negedge sys_clk);
    check("mr_after_rdy",  rec_readyH, 1'b0);
    check("mr_after_ferr", ferr_cnt,   1);
    send_frame(8'h7E, 1'b1, e_tmp);
    check("x7e_data",  rec_dataH,  8'h7E);
    check("x7e_ready", rec_readyH, 1'b1);
    ack_pulse();
    check("x7e_ack",   rec_readyH, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
